// File: rtl/rsbus_slot_arbiter.sv
// rsbus_slot_arbiter: shares empty ring frame slots round-robin between NREQ local requesters.
// Define RSBUS_SLOT_ARB_PRIO_EN to give requester 0 strict priority over the rotation.
module rsbus_slot_arbiter #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_sof,
    input  logic [11:0]        i_ctrl,
    input  logic [71:0]        i_bus,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*12-1:0] req_ctrl,
    input  logic [NREQ*72-1:0] req_bus,
    output logic [NREQ-1:0]    req_rd,
    output logic [NREQ-1:0]    req_done,
    output logic [NREQ-1:0]    req_abort,
    output logic               o_sof,
    output logic [11:0]        o_ctrl,
    output logic [71:0]        o_bus,
    output logic               o_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {SYNC, PASS, INSERT} state_t;

    state_t          state, state_nx;
    logic [3:0]      word_cnt, idx;
    logic [PW-1:0]   rr_ptr, rr_nx, gnt, gnt_nx, pick, gnt_inc;
    logic            grant, misalign;
    logic [NREQ-1:0] rd, done, abort;
    logic [11:0]     ctrl_d;
    logic [71:0]     bus_d;

    // word_cnt holds the previous word's slot index; idx is the current word's
    assign idx      = i_sof ? 4'd0 : ((word_cnt == LAST) ? LAST : word_cnt + 4'd1);
    assign misalign = (state != SYNC) && (i_sof ? (word_cnt != LAST) : (word_cnt == LAST));
    assign grant    = i_sof && !i_ctrl[11] && (|req_valid);
    assign gnt_inc  = (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    // descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) pick = PW'((int'(rr_ptr) + k) % NREQ);
`ifdef RSBUS_SLOT_ARB_PRIO_EN
        if (req_valid[0]) pick = '0;
`endif
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        rr_nx    = rr_ptr;
        rd       = '0;
        done     = '0;
        abort    = '0;
        ctrl_d   = i_ctrl;
        bus_d    = i_bus;
        if (state == INSERT && i_sof) abort[gnt] = 1'b1;
        if (i_sof) begin
            state_nx = grant ? INSERT : PASS;
            gnt_nx   = pick;
            if (grant) begin
                rd[pick] = 1'b1;
                ctrl_d   = req_ctrl[int'(pick)*12 +: 12];
                ctrl_d[11] = 1'b1;
                bus_d    = req_bus[int'(pick)*72 +: 72];
            end
        end else if (state == INSERT) begin
            rd[gnt] = 1'b1;
            ctrl_d  = req_ctrl[int'(gnt)*12 +: 12];
            bus_d   = req_bus[int'(gnt)*72 +: 72];
            if (idx == LAST) begin
                done[gnt] = 1'b1;
                state_nx  = PASS;
`ifdef RSBUS_SLOT_ARB_PRIO_EN
                if (gnt != '0) rr_nx = gnt_inc;
`else
                rr_nx = gnt_inc;
`endif
            end
        end
    end

    // strobes are combinational so a reset clears them at once
    assign req_rd    = rst_n ? rd : '0;
    assign req_done  = rst_n ? done : '0;
    assign req_abort = rst_n ? abort : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            word_cnt <= '0;
            rr_ptr   <= '0;
            gnt      <= '0;
            o_sof    <= 1'b0;
            o_ctrl   <= '0;
            o_bus    <= '0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            word_cnt <= idx;
            rr_ptr   <= rr_nx;
            gnt      <= gnt_nx;
            o_sof    <= i_sof;
            o_ctrl   <= ctrl_d;
            o_bus    <= bus_d;
            o_err    <= o_err | misalign;
        end
    end
endmodule

// File: tb/tb_rsbus_slot_arbiter.sv
// tb_rsbus_slot_arbiter: randomized frame traffic against a slot-level reference model.
// Honours RSBUS_SLOT_ARB_PRIO_EN the same way as the design.
module tb_rsbus_slot_arbiter;
    localparam int NREQ = 4;
    localparam int FL   = 11;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_sof = 1'b0;
    logic [11:0]        i_ctrl = '0;
    logic [71:0]        i_bus = '0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*12-1:0] req_ctrl = '0;
    logic [NREQ*72-1:0] req_bus = '0;
    logic [NREQ-1:0]    req_rd, req_done, req_abort;
    logic               o_sof, o_err;
    logic [11:0]        o_ctrl;
    logic [71:0]        o_bus;

    rsbus_slot_arbiter #(.NREQ(NREQ), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .i_sof(i_sof), .i_ctrl(i_ctrl), .i_bus(i_bus),
        .req_valid(req_valid), .req_ctrl(req_ctrl), .req_bus(req_bus),
        .req_rd(req_rd), .req_done(req_done), .req_abort(req_abort),
        .o_sof(o_sof), .o_ctrl(o_ctrl), .o_bus(o_bus), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // slot-level model: position in frame, active insertion, rotation pointer
    bit          m_synced;
    int          m_pos, m_ins, m_rr;
    bit          m_err;
    logic        q_sof;
    logic [11:0] q_ctrl;
    logic [71:0] q_bus;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_pos = 0; m_ins = -1; m_rr = 0; m_err = 0;
        q_sof = 0; q_ctrl = '0; q_bus = '0;
    endtask

    function automatic int choose(input logic [NREQ-1:0] rv);
        int g = -1;
`ifdef RSBUS_SLOT_ARB_PRIO_EN
        if (rv[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && rv[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        return g;
    endfunction

    task automatic step(input bit sof, input bit occ, input logic [NREQ-1:0] rv, input bit rst);
        logic [95:0]     r;
        logic [NREQ-1:0] e_rd, e_done, e_abort;
        logic [11:0]     e_ctrl;
        logic [71:0]     e_bus;
        int              pos;
        bit              mis;
        i_sof = sof;
        r = {$urandom(), $urandom(), $urandom()};
        i_ctrl = {occ, r[82:72]};
        i_bus = r[71:0];
        for (int n = 0; n < NREQ; n++) begin
            r = {$urandom(), $urandom(), $urandom()};
            req_ctrl[n*12 +: 12] = r[83:72];
            req_bus[n*72 +: 72] = r[71:0];
        end
        req_valid = rv;
        if (rst) rst_n = 1'b0;
        #4;
        if (rst) begin
            check("rst_sof", o_sof, 0);
            check("rst_ctrl", o_ctrl, 0);
            check("rst_bus", o_bus, 0);
            check("rst_rd", req_rd, 0);
            check("rst_done", req_done, 0);
            check("rst_abort", req_abort, 0);
            check("rst_err", o_err, 0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        pos = sof ? 0 : m_pos + 1;
        mis = m_synced && (sof ? (m_pos != FL - 1) : (m_pos >= FL - 1));
        e_abort = '0;
        e_rd = '0;
        e_done = '0;
        e_ctrl = i_ctrl;
        e_bus = i_bus;
        if (sof && m_ins >= 0) e_abort[m_ins] = 1'b1;
        if (sof) m_ins = occ ? -1 : choose(rv);
        if (m_ins >= 0) begin
            e_rd[m_ins] = 1'b1;
            e_ctrl = req_ctrl[m_ins*12 +: 12];
            if (sof) e_ctrl[11] = 1'b1;
            e_bus = req_bus[m_ins*72 +: 72];
            if (pos == FL - 1) begin
                e_done[m_ins] = 1'b1;
`ifdef RSBUS_SLOT_ARB_PRIO_EN
                if (m_ins != 0) m_rr = (m_ins + 1) % NREQ;
`else
                m_rr = (m_ins + 1) % NREQ;
`endif
                m_ins = -1;
            end
        end
        check("req_rd", req_rd, e_rd);
        check("req_done", req_done, e_done);
        check("req_abort", req_abort, e_abort);
        check("o_sof", o_sof, q_sof);
        check("o_ctrl", o_ctrl, q_ctrl);
        check("o_bus", o_bus, q_bus);
        check("o_err", o_err, m_err);
        m_err = m_err | mis;
        q_sof = sof; q_ctrl = e_ctrl; q_bus = e_bus;
        m_pos = pos;
        m_synced = m_synced | sof;
        @(negedge clk);
    endtask

    task automatic frame(input bit occ, input logic [NREQ-1:0] rv, input int len);
        for (int i = 0; i < len; i++) step(i == 0, occ, rv, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_sof", o_sof, 0);
        check("reset_ctrl", o_ctrl, 0);
        check("reset_rd", req_rd, 0);
        check("reset_err", o_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) frame(1'b1, 4'b1111, FL);
        frame(1'b0, 4'b0100, FL);
        for (int i = 0; i < 8; i++) frame(1'b0, 4'b1111, FL);
        for (int i = 0; i < 4; i++) frame(1'b0, 4'b1110, FL);
        frame(1'b0, 4'b0010, 6);
        frame(1'b1, 4'b0000, FL);
        frame(1'b0, 4'b0001, FL);
        for (int i = 0; i < 4; i++) step(i == 0, 1'b0, 4'b1000, 1'b0);
        step(1'b0, 1'b0, 4'b1000, 1'b1);
        frame(1'b0, 4'b1111, FL);
        for (int f = 0; f < 300; f++) begin
            int  len;
            bit  occ;
            bit  rst;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 14)) : FL;
            occ = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < len; i++) begin
                rst = (i == 4) && ($urandom_range(0, 29) == 0);
                step(i == 0, occ, NREQ'($urandom()), rst);
                if (rst) break;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rsbus_slot_arbiter.md
Name: rsbus_slot_arbiter

Overview:
- Sits directly downstream of the ring frame generator, before the rsbus ring register stage.
- Tracks the fixed 11-word frame slots the generator emits.
- Detects empty slots and shares them round-robin between NREQ local requesters, each of which injects one whole frame per grant.
- Occupied slots pass through unchanged, so the block is the single point that sequences local traffic onto the ring.

Parameters:
- NREQ, 4, number of local requesters (2..8).
- FRAME_LEN, 11, words per frame slot, including the header word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_sof  in  1  start-of-frame from frame generator; marks the header word
- i_ctrl  in  12  ring control word; bit 11 = slot occupied
- i_bus  in  72  ring data word
- req_valid  in  NREQ  requester n has a complete frame ready
- req_ctrl  in  NREQ*12  per-requester control word, slice n = [12n+11:12n]
- req_bus  in  NREQ*72  per-requester data word, slice n = [72n+71:72n]
- req_rd  out  NREQ  one-hot word pop; requester advances to its next word on the following cycle
- req_done  out  NREQ  one-cycle pulse when the last word of a frame is taken
- req_abort  out  NREQ  one-cycle pulse when an insertion is cut short by resync
- o_sof  out  1  registered i_sof
- o_ctrl  out  12  ring control word out
- o_bus  out  72  ring data word out
- o_err  out  1  sticky frame-misalignment flag

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=SYNC; word_cnt=0; o_err=0.
- Latency: one cycle, input to output, for both pass-through and inserted words. o_sof is i_sof delayed 1.
- word_cnt: 4 bits, from 0 to FRAME_LEN-1. It loads 0 on i_sof, otherwise increments. Past FRAME_LEN-1 it holds until the next i_sof.
- States:
  - SYNC: forward input. On i_sof go to the decide logic, which runs in the same cycle.
  - Decide, on the i_sof cycle:
    - If i_ctrl[11]=1 (slot occupied), or no req_valid bit is set: go to PASS.
    - Otherwise grant g = the first set req_valid bit searching from rr_ptr upward, with modulo-NREQ wrap. Go to INSERT.
  - PASS: forward i_ctrl/i_bus. Leave on the next i_sof (decide again).
  - INSERT: output = req_ctrl[g]/req_bus[g]; req_rd[g]=1 every cycle of the slot, including the header cycle.
    - On word_cnt=FRAME_LEN-1: pulse req_done[g], set rr_ptr=(g+1) mod NREQ, go to SYNC-equivalent wait (next i_sof decides).
    - The inserted header must carry ctrl[11]=1; the block forces o_ctrl[11]=1 on the header word of an inserted frame.
- Grant is held for the whole slot. req_valid deasserting mid-insertion is ignored (requester contract violation, not checked).
- Misalignment:
  - Condition: i_sof while word_cnt != FRAME_LEN-1 and state != SYNC, or word_cnt reaching FRAME_LEN-1 with no i_sof on the following cycle.
  - Response: set o_err (sticky until reset). If in INSERT, pulse req_abort[g] and do not pulse req_done[g]; rr_ptr is unchanged. Treat the i_sof as a new frame and decide.
- Simultaneous events: i_sof on the cycle after the last inserted word is the normal case. The new decide uses the already-updated rr_ptr.
- rst_n asserted mid-insertion: all outputs clear immediately (async). No req_done/req_abort is generated. The requester must flush its frame on reset.
- Single grant only: req_rd, req_done and req_abort are each one-hot or zero.

Optional Feature:
- Macro: RSBUS_SLOT_ARB_PRIO_EN.
- Defined: requester 0 has strict priority. If req_valid[0]=1 at decide it wins regardless of rr_ptr; rr_ptr is not advanced by requester-0 grants. Remaining requesters rotate round-robin among themselves.
- Undefined: plain round-robin over all NREQ requesters.

Test Plan:
- Pass-through: i_sof every 11 cycles, occupied headers (i_ctrl[11]=1), req_valid=4'b1111 -> o_* equals input delayed 1; req_rd stays 0; o_err=0.
- Single insert: empty slot, req_valid=4'b0100 -> req_rd[2] high for 11 cycles from the sof cycle; o_ctrl[11]=1 on the header; req_done[2] pulses on cycle 10; rr_ptr becomes 3.
- Round-robin: req_valid=4'b1111 held, 8 consecutive empty slots -> grant order 0,1,2,3,0,1,2,3 (macro undefined).
- Priority (macro defined): same stimulus -> order 0,0,0,... . With req_valid[0]=0 after slot 2 -> 1,2,3,1.
- Misalignment: i_sof injected at word_cnt=5 during an insert of requester 1 -> req_abort[1] pulses, o_err=1 and stays set, new slot decided on that cycle, rr_ptr unchanged.
- Reset mid-insert: rst_n low at word_cnt=4 -> o_sof/o_ctrl/o_bus/req_rd are 0 immediately; after release, the first i_sof is handled from SYNC with rr_ptr=0.
